// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor tracking controller: FSM state encoding,
// default speed constants and a symmetric saturation helper.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STOP   = 3'd1,
    ST_TRACK  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SEARCH = 3'd4
  } state_t;

  localparam int DEF_VMAX       = 200;
  localparam int DEF_VSTEP      = 20;
  localparam int DEF_VREV       = 100;
  localparam int DEF_SEARCH_DPS = 80;
  localparam int DEF_RAMP_STEP  = 20;

  function automatic int sat_sym(input int v, input int lim);
    if (v > lim)       return lim;
    else if (v < -lim) return -lim;
    else               return v;
  endfunction

endpackage

// File: rtl/motor_ramp.sv
// Per-side slew limiter: on each tick the output steps toward the target by at
// most RAMP_STEP; clear forces the output to zero on the next clock.
module motor_ramp import motor_ctrl_pkg::*; #(
  parameter int NB_DPS    = 16,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     tick,
  input  logic signed [NB_DPS-1:0] target,
  output logic signed [NB_DPS-1:0] out
);

  logic signed [NB_DPS:0] diff;
  logic signed [NB_DPS:0] step;

  // One extra bit keeps target-out from wrapping across the full signed range.
  always_comb begin
    diff = (NB_DPS+1)'(target) - (NB_DPS+1)'(out);
    step = (NB_DPS+1)'(RAMP_STEP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      out <= '0;
    end else if (tick) begin
      if (diff > step)       out <= out + NB_DPS'(RAMP_STEP);
      else if (diff < -step) out <= out - NB_DPS'(RAMP_STEP);
      else                   out <= target;
    end
  end

endmodule

// File: rtl/motor_track_ctrl.sv
// Object-tracking motor controller: a frame-driven FSM chooses per-side speed
// targets from centroid and proximity, and two slew limiters drive the outputs.
module motor_track_ctrl import motor_ctrl_pkg::*; #(
  parameter int NB_DPS        = 16,
  parameter int NB_CENT       = 8,
  parameter int NB_PROX       = 3,
  parameter int VMAX          = DEF_VMAX,
  parameter int VSTEP         = DEF_VSTEP,
  parameter int VREV          = DEF_VREV,
  parameter int DEADBAND      = 16,
  parameter int K_SHIFT       = 1,
  parameter int RAMP_STEP     = DEF_RAMP_STEP,
  parameter int HOLD_FRAMES   = 4,
  parameter int SEARCH_FRAMES = 60,
  parameter int SEARCH_DPS    = DEF_SEARCH_DPS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NB_CENT-1:0]        centroid,
  input  logic                      new_centroid,
  input  logic [NB_PROX-1:0]        proximity,
  input  logic                      search_en,
  input  logic                      tick,
  output logic signed [NB_DPS-1:0]  motor_dps_left_o,
  output logic signed [NB_DPS-1:0]  motor_dps_rght_o,
  output logic [2:0]                state_o
);

  localparam int DPS_LIM  = 2**(NB_DPS-1) - 1;
  localparam int CENTRE   = 2**(NB_CENT-1);
  localparam int PROX_TOP = 2**NB_PROX - 1;
  localparam int LW       = (HOLD_FRAMES   < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam int SW       = (SEARCH_FRAMES < 1) ? 1 : $clog2(SEARCH_FRAMES + 1);
  localparam int LMAX     = 2**LW - 1;
  localparam int SMAX     = 2**SW - 1;

  state_t                   state;
  logic [NB_CENT-1:0]       last_cent;
  logic [LW-1:0]            lost_cnt;
  logic [SW-1:0]            search_cnt;
  logic signed [NB_DPS-1:0] tgt_l, tgt_r;

  logic frame_valid, frame_lost;
  int   vel, vabs, err, aerr, adj, slow_mag, slow;
  int   track_l, track_r, lost_inc, search_inc;

  always_comb begin
    frame_valid = new_centroid && (centroid != '0);
    frame_lost  = new_centroid && (centroid == '0);

    vel = (int'(proximity) == PROX_TOP) ? -VREV : VMAX - int'(proximity) * VSTEP;
    vel = sat_sym(vel, DPS_LIM);
    vabs = (vel < 0) ? -vel : vel;

    err  = int'(last_cent) - CENTRE;
    aerr = (err < 0) ? -err : err;
    adj  = aerr >> K_SHIFT;
    slow_mag = (vabs > adj) ? vabs - adj : 0;
    slow = (vel < 0) ? -slow_mag : slow_mag;

    // Slowing the left side steers left; in reverse the steering sense flips.
    if (aerr < DEADBAND) begin
      track_l = vel;
      track_r = vel;
    end else if ((err < 0) == (vel >= 0)) begin
      track_l = slow;
      track_r = vel;
    end else begin
      track_l = vel;
      track_r = slow;
    end

    lost_inc   = int'(lost_cnt) + 1;
    search_inc = int'(search_cnt) + 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_cent  <= NB_CENT'(CENTRE);
      lost_cnt   <= '0;
      search_cnt <= '0;
      tgt_l      <= '0;
      tgt_r      <= '0;
    end else if (!enable) begin
      state      <= ST_IDLE;
      lost_cnt   <= '0;
      search_cnt <= '0;
      tgt_l      <= '0;
      tgt_r      <= '0;
    end else begin
      if (frame_valid) last_cent <= centroid;

      case (state)
        ST_TRACK: begin
          tgt_l <= NB_DPS'(track_l);
          tgt_r <= NB_DPS'(track_r);
        end
        ST_HOLD: ;
        ST_SEARCH: begin
          if (int'(last_cent) < CENTRE) begin
            tgt_l <= NB_DPS'(-SEARCH_DPS);
            tgt_r <= NB_DPS'(SEARCH_DPS);
          end else begin
            tgt_l <= NB_DPS'(SEARCH_DPS);
            tgt_r <= NB_DPS'(-SEARCH_DPS);
          end
        end
        default: begin
          tgt_l <= '0;
          tgt_r <= '0;
        end
      endcase

      case (state)
        ST_IDLE: state <= ST_STOP;
        ST_STOP: begin
          if (frame_valid) begin
            state      <= ST_TRACK;
            lost_cnt   <= '0;
            search_cnt <= '0;
          end
        end
        ST_TRACK: begin
          if (frame_lost) begin
            state    <= ST_HOLD;
            lost_cnt <= LW'(1);
          end
        end
        ST_HOLD: begin
          if (frame_valid) begin
            state      <= ST_TRACK;
            lost_cnt   <= '0;
            search_cnt <= '0;
          end else if (frame_lost) begin
            lost_cnt <= LW'((lost_inc > LMAX) ? LMAX : lost_inc);
            if (lost_inc >= HOLD_FRAMES) begin
              state      <= search_en ? ST_SEARCH : ST_STOP;
              search_cnt <= '0;
            end
          end
        end
        ST_SEARCH: begin
          if (frame_valid) begin
            state      <= ST_TRACK;
            lost_cnt   <= '0;
            search_cnt <= '0;
          end else if (!search_en) begin
            state      <= ST_STOP;
            lost_cnt   <= '0;
            search_cnt <= '0;
          end else if (frame_lost) begin
            if (search_inc >= SEARCH_FRAMES) begin
              state      <= ST_STOP;
              lost_cnt   <= '0;
              search_cnt <= '0;
            end else begin
              search_cnt <= SW'((search_inc > SMAX) ? SMAX : search_inc);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_o = state;

  motor_ramp #(.NB_DPS(NB_DPS), .RAMP_STEP(RAMP_STEP)) u_ramp_left (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!enable),
    .tick   (tick),
    .target (tgt_l),
    .out    (motor_dps_left_o)
  );

  motor_ramp #(.NB_DPS(NB_DPS), .RAMP_STEP(RAMP_STEP)) u_ramp_rght (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!enable),
    .tick   (tick),
    .target (tgt_r),
    .out    (motor_dps_rght_o)
  );

endmodule

// File: doc/motor_track_ctrl.md
MOTOR_TRACK_CTRL -- requirements
Module: motor_track_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 SHALL have parameters (name, default, meaning):
- NB_DPS, 16, signed motor command width.
- NB_CENT, 8, centroid width.
- NB_PROX, 3, proximity width.
- VMAX, 200, base dps at proximity 0.
- VSTEP, 20, dps decrement per proximity code.
- VREV, 100, reverse dps magnitude at the top proximity code.
- DEADBAND, 16, centroid error band treated as centred.
- K_SHIFT, 1, right-shift applied to |error|.
- RAMP_STEP, 20, maximum output change per tick.
- HOLD_FRAMES, 4, lost frames before searching.
- SEARCH_FRAMES, 60, search frames before stopping.
- SEARCH_DPS, 80, spin speed.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- enable, in, 1, 0 forces zero outputs.
- centroid, in, NB_CENT, object column; 0 means no object.
- new_centroid, in, 1, one-cycle frame strobe.
- proximity, in, NB_PROX, distance code; higher means closer.
- search_en, in, 1, allows the SEARCH state.
- tick, in, 1, ramp update strobe.
- motor_dps_left_o, out, NB_DPS, signed left command.
- motor_dps_rght_o, out, NB_DPS, signed right command.
- state_o, out, 3, current FSM state.

Function
REQ-004 SHALL run an FSM with states IDLE=0, STOP=1, TRACK=2, HOLD=3, SEARCH=4.
REQ-005 SHALL force state IDLE, counters 0 and both outputs 0 in the cycle after enable=0, regardless of state or ramp; enable=0 dominates all other events.
REQ-006 SHALL move IDLE->STOP on enable=1.
REQ-007 SHALL move STOP/HOLD/SEARCH->TRACK on new_centroid with centroid!=0, clearing both counters; a valid frame wins over simultaneous counter expiry.
REQ-008 SHALL move TRACK->HOLD on new_centroid with centroid==0, setting lost_cnt=1.
REQ-009 SHALL increment lost_cnt by 1 per invalid frame in HOLD, saturating.
REQ-010 SHALL, when lost_cnt reaches HOLD_FRAMES, go to SEARCH if search_en=1, else to STOP.
REQ-011 SHALL increment search_cnt per invalid frame in SEARCH; at SEARCH_FRAMES go to STOP; search_en falling in SEARCH goes to STOP.
REQ-012 SHALL latch last_cent (centroid) on every valid new_centroid.
REQ-013 SHALL compute the base velocity as vel = VMAX - proximity*VSTEP for proximity < 2^NB_PROX-1, and vel = -VREV at the top code.
REQ-014 SHALL compute err = last_cent - 2^(NB_CENT-1), signed NB_CENT+1 bits.
REQ-015 SHALL compute the slow side as adj=|err|>>K_SHIFT, with slow magnitude = max(|vel|-adj, 0) carrying the sign of vel.
REQ-016 SHALL set TRACK targets:
- |err| < DEADBAND: both = vel.
- err<0, forward: left=slow, right=vel.
- err>0, forward: left=vel, right=slow.
- Reverse (vel<0): sides swapped.
REQ-017 SHALL keep targets frozen in HOLD at their last TRACK values.
REQ-018 SHALL set SEARCH targets as a spin toward the last side:
- last_cent < centre: left=-SEARCH_DPS, right=+SEARCH_DPS.
- Otherwise: left=+SEARCH_DPS, right=-SEARCH_DPS.
REQ-019 SHALL set STOP and IDLE targets to 0.
REQ-020 SHALL update targets in the cycle after the state/last_cent change (1-cycle latency).
REQ-021 SHALL, on each tick, move each output toward its target by min(|target-out|, RAMP_STEP), crossing zero without special handling; outputs hold between ticks.
REQ-022 SHALL keep all arithmetic saturating at ±(2^(NB_DPS-1)-1), with no wrap.

Reset
REQ-023 SHALL, while rst_n=0 at clk, set state=IDLE, outputs=0, last_cent=2^(NB_CENT-1), lost_cnt=0, search_cnt=0, targets=0; reset mid-ramp zeroes outputs immediately.

Structure
REQ-024 SHALL place the state encoding and the default speed constants (VMAX, VSTEP, VREV, SEARCH_DPS, RAMP_STEP) in a shared motor_ctrl package.
REQ-025 SHALL implement the per-side slew limiter as a sub-module motor_ramp, instantiated twice.

Verification
REQ-026 SHALL drive centroid=128, proximity=0 then 10 ticks -> outputs 20,40,...,200 on both sides; state TRACK.
REQ-027 SHALL drive centroid=40, proximity=2, settled -> left=116, right=160.
REQ-028 SHALL drive centroid=200, proximity=7, settled -> left=-64, right=-100.
REQ-029 SHALL, after last_cent=200 and search_en=1, drive 4 invalid frames -> SEARCH with targets left=+80, right=-80, then 60 more invalid frames -> STOP with ramp to 0; a valid frame on the 60th strobe -> TRACK instead.
REQ-030 SHALL drop enable mid-ramp at outputs 120/120 -> outputs 0 next cycle, state IDLE; enable high -> STOP.
REQ-031 SHALL assert rst_n=0 during SEARCH -> all outputs and counters at reset values next cycle.
